// File: rtl/reg_file_ctx.sv
// reg_file_ctx: dual-read, single-write register file with a shadow bank for
// interrupt context save/restore and a sequential clear sweep out of reset.
// Optional feature: define REG_FILE_BYPASS_EN to forward DIN to the read ports
// during an IDLE write to the same address.
module reg_file_ctx #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DIN,
  input  logic [ADDR_W-1:0] ADRX,
  input  logic [ADDR_W-1:0] ADRY,
  input  logic              RF_WR,
  input  logic              SAVE,
  input  logic              RESTORE,
  output logic [DATA_W-1:0] DX_OUT,
  output logic [DATA_W-1:0] DY_OUT,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_SAVE,
    S_RESTORE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              done_q;
  logic [DATA_W-1:0] live_q   [DEPTH];
  logic [DATA_W-1:0] shadow_q [DEPTH];

  logic [DATA_W-1:0] dx_d;
  logic [DATA_W-1:0] dy_d;

  // Sweep controller and both banks; reset parks the sweep on entry 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_CLEAR;
      idx_q       <= '0;
      done_q      <= 1'b0;
      live_q[0]   <= '0;
      shadow_q[0] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          live_q[idx_q]   <= '0;
          shadow_q[idx_q] <= '0;
          idx_q           <= idx_q + 1'b1;
          if (idx_q == '1) state_q <= S_IDLE;
        end
        S_IDLE: begin
          // The write lands at the same edge the request is accepted, so the
          // first SAVE copy already sees it and a RESTORE overwrites it.
          if (RF_WR) live_q[ADRX] <= DIN;
          if (SAVE) begin
            state_q <= S_SAVE;
            idx_q   <= '0;
          end else if (RESTORE) begin
            state_q <= S_RESTORE;
            idx_q   <= '0;
          end
        end
        S_SAVE: begin
          shadow_q[idx_q] <= live_q[idx_q];
          idx_q           <= idx_q + 1'b1;
          if (idx_q == '1) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        S_RESTORE: begin
          live_q[idx_q] <= shadow_q[idx_q];
          idx_q         <= idx_q + 1'b1;
          if (idx_q == '1) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_CLEAR;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Asynchronous read of the live bank, masked during the clear sweep.
  always_comb begin
    dx_d = live_q[ADRX];
    dy_d = live_q[ADRY];
    if (state_q == S_CLEAR) begin
      dx_d = '0;
      dy_d = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    if (state_q == S_IDLE && RF_WR) begin
      dx_d = DIN;
      if (ADRY == ADRX) dy_d = DIN;
    end
`endif
  end

  assign DX_OUT = dx_d;
  assign DY_OUT = dy_d;
  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = done_q;

endmodule

// File: tb/tb_reg_file_ctx.sv
// tb_reg_file_ctx: directed bench for reg_file_ctx at default parameters.
module tb_reg_file_ctx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DIN;
  logic [4:0] ADRX;
  logic [4:0] ADRY;
  logic       RF_WR;
  logic       SAVE;
  logic       RESTORE;
  logic [7:0] DX_OUT;
  logic [7:0] DY_OUT;
  logic       BUSY;
  logic       DONE;

  int vectors = 0;
  int errors  = 0;

  reg_file_ctx #(.DATA_W(8), .ADDR_W(5)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DIN     (DIN),
    .ADRX    (ADRX),
    .ADRY    (ADRY),
    .RF_WR   (RF_WR),
    .SAVE    (SAVE),
    .RESTORE (RESTORE),
    .DX_OUT  (DX_OUT),
    .DY_OUT  (DY_OUT),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    ADRX  = a;
    DIN   = d;
    RF_WR = 1'b1;
    tick();
    RF_WR = 1'b0;
  endtask

  // Fill every register with K+1 (inc=1) or 0xFF (inc=0).
  task automatic fill(input bit inc);
    for (int k = 0; k < 32; k++) wr(5'(k), inc ? 8'(k + 1) : 8'hFF);
  endtask

  // Read all registers and compare against K+1 / 0xFF / 0.
  task automatic read_all(input string tag, input int mode);
    logic [7:0] e;
    for (int k = 0; k < 32; k++) begin
      ADRX = 5'(k);
      ADRY = 5'(31 - k);
      #1;
      e = (mode == 1) ? 8'(k + 1) : (mode == 2) ? 8'hFF : 8'h00;
      chk({tag, "_dx"}, DX_OUT, e);
      e = (mode == 1) ? 8'(32 - k) : (mode == 2) ? 8'hFF : 8'h00;
      chk({tag, "_dy"}, DY_OUT, e);
    end
  endtask

  // Edges after the current point until DONE is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (DONE) break;
    end
  endtask

  // Edges until BUSY falls (bounded), counting any DONE pulses on the way.
  task automatic wait_idle(output int n, output int dones);
    n = 0;
    dones = 0;
    while (n < 100 && BUSY) begin
      tick();
      n++;
      if (DONE) dones++;
    end
  endtask

  // Pulse one request for one edge and return the edge count to DONE.
  task automatic request(input bit sv, input bit rs, output int n);
    SAVE    = sv;
    RESTORE = rs;
    tick();
    SAVE    = 1'b0;
    RESTORE = 1'b0;
    wait_done(n);
  endtask

  initial begin
    int n;
    int dones;
    RST = 1'b1; DIN = '0; ADRX = '0; ADRY = '0;
    RF_WR = 1'b0; SAVE = 1'b0; RESTORE = 1'b0;

    // Reset sweep
    tick();
    tick();
    chk("rst_busy", BUSY, 1'b1);
    chk("rst_done", DONE, 1'b0);
    chk("rst_dx", DX_OUT, 8'h00);
    chk("rst_dy", DY_OUT, 8'h00);
    RST = 1'b0;
    wait_idle(n, dones);
    chk("clear_cycles", n, 32);
    chk("clear_dones", dones, 0);
    read_all("clear_rd", 0);
    request(1'b1, 1'b0, n);
    chk("zero_save_lat", n, 32);
    request(1'b0, 1'b1, n);
    chk("zero_rest_lat", n, 32);
    read_all("zero_rest_rd", 0);

    // Write/read, including same-cycle behaviour
    ADRX = 5'd3; ADRY = 5'd3; DIN = 8'hA5; RF_WR = 1'b1;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("wcycle_dx", DX_OUT, 8'hA5);
    chk("wcycle_dy", DY_OUT, 8'hA5);
`else
    chk("wcycle_dx", DX_OUT, 8'h00);
    chk("wcycle_dy", DY_OUT, 8'h00);
`endif
    tick();
    RF_WR = 1'b0;
    wr(5'd7, 8'h3C);
    ADRX = 5'd3; ADRY = 5'd7;
    #1;
    chk("rd_r3", DX_OUT, 8'hA5);
    chk("rd_r7", DY_OUT, 8'h3C);

    // Context round trip
    fill(1'b1);
    request(1'b1, 1'b0, n);
    chk("rt_save_lat", n, 32);
    chk("rt_save_busy", BUSY, 1'b0);
    tick();
    chk("rt_done_width", DONE, 1'b0);
    fill(1'b0);
    read_all("rt_ff", 2);
    request(1'b0, 1'b1, n);
    chk("rt_rest_lat", n, 32);
    read_all("rt_rd", 1);

    // Busy rejection: write and RESTORE during a SAVE are dropped
    SAVE = 1'b1;
    tick();
    SAVE = 1'b0;
    repeat (5) tick();
    ADRX = 5'd5; DIN = 8'h77; RF_WR = 1'b1; RESTORE = 1'b1;
    #1;
    chk("busy_nobypass", DX_OUT, 8'h06);
    tick();
    RF_WR = 1'b0; RESTORE = 1'b0;
    wait_done(n);
    chk("busy_save_lat", n, 32 - 6);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (DONE || BUSY) dones++;
    end
    chk("busy_no_restore", dones, 0);
    ADRX = 5'd5;
    #1;
    chk("busy_r5", DX_OUT, 8'h06);

    // Simultaneous write + SAVE + RESTORE: write lands, SAVE wins
    ADRX = 5'd2; DIN = 8'h11; RF_WR = 1'b1; SAVE = 1'b1; RESTORE = 1'b1;
    tick();
    RF_WR = 1'b0; SAVE = 1'b0; RESTORE = 1'b0;
    wait_done(n);
    chk("sim_save_lat", n, 32);
    wr(5'd2, 8'h22);
    request(1'b0, 1'b1, n);
    chk("sim_rest_lat", n, 32);
    ADRX = 5'd2; ADRY = 5'd3;
    #1;
    chk("sim_r2", DX_OUT, 8'h11);
    chk("sim_r3", DY_OUT, 8'h04);

    // Reset mid-RESTORE
    fill(1'b0);
    RESTORE = 1'b1;
    tick();
    RESTORE = 1'b0;
    repeat (10) tick();
    ADRX = 5'd4; ADRY = 5'd20;
    #1;
    chk("mid_copied", DX_OUT, 8'h05);
    chk("mid_pending", DY_OUT, 8'hFF);
    RST = 1'b1;
    tick();
    chk("mid_rst_busy", BUSY, 1'b1);
    chk("mid_rst_done", DONE, 1'b0);
    chk("mid_rst_dx", DX_OUT, 8'h00);
    RST = 1'b0;
    wait_idle(n, dones);
    chk("mid_clear_cycles", n, 32);
    chk("mid_clear_dones", dones, 0);
    read_all("mid_live", 0);
    request(1'b0, 1'b1, n);
    chk("mid_rest_lat", n, 32);
    read_all("mid_shadow", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
